// File: rtl/jt12_pres_pkg.sv
// Shared constants, state encoding and decode helpers for the jt12 prescaler controller.
package jt12_pres_pkg;

  localparam logic [7:0] PRES_2D   = 8'h2D;
  localparam logic [7:0] PRES_2E   = 8'h2E;
  localparam logic [7:0] PRES_2F   = 8'h2F;
  localparam logic [1:0] DIV_RESET = 2'b10;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } pres_state_e;

  function automatic logic is_pres_cmd(input logic [7:0] a);
    return (a == PRES_2D) || (a == PRES_2E) || (a == PRES_2F);
  endfunction

  // 0x2D/0x2E set bits of the pending selection, 0x2F clears it.
  function automatic logic [1:0] pres_merge(input logic [1:0] pend, input logic [7:0] a);
    case (a)
      PRES_2D: return pend | 2'b10;
      PRES_2E: return pend | 2'b01;
      default: return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/jt12_busy_cnt.sv
// Write-busy timer: counts BUSY_CYC cen ticks after each load; a load while busy restarts it.
module jt12_busy_cnt #(
  parameter int BUSY_CYC = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic cen,
  input  logic load,
  output logic busy
);

  localparam logic [5:0] LOAD_VAL = 6'(BUSY_CYC);

  logic [5:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = LOAD_VAL;
    end else if (cen && (cnt_q != 6'd0)) begin
      cnt_d = cnt_q - 6'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 6'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy = (cnt_q != 6'd0);

endmodule

// File: rtl/jt12_pres_ctrl.sv
// CPU write decoder and prescaler-select controller for the jt12 FM core.
// Define JT12_PRES_LOCK_EN to ignore prescaler commands and pin div_setting at DIV_RESET.
module jt12_pres_ctrl
  import jt12_pres_pkg::*;
#(
  parameter int BUSY_CYC = 32
) (
  input  logic        rst,
  input  logic        clk,
  input  logic        cen,
  input  logic        clk_en_in,
  input  logic        cs_n,
  input  logic        wr_n,
  input  logic        a0,
  input  logic [7:0]  din,
  output logic [1:0]  div_setting,
  output logic [7:0]  addr,
  output logic [7:0]  dout,
  output logic        data_wr,
  output logic        busy,
  output logic        pres_upd,
  output pres_state_e dbg_state
);

  // Write protocol: the strobe (~cs_n & ~wr_n) is registered; one write event fires
  // in the cycle its registered copy rises, and a0/din are taken from that same cycle.
  logic        strb_q, strb_prev_q;
  logic        wr_ev, addr_ev, data_ev, presc_cmd, apply;
  pres_state_e state_q, state_d;
  logic [1:0]  pend_q, pend_d, div_q, div_d;
  logic [7:0]  addr_q, addr_d, dout_q, dout_d;
  logic        data_wr_q, data_wr_d, pres_upd_q, pres_upd_d;

  assign wr_ev   = strb_q & ~strb_prev_q;
  assign addr_ev = wr_ev & ~a0;
  assign data_ev = wr_ev & a0;
  assign apply   = (state_q == ST_PENDING) & cen & clk_en_in;

`ifdef JT12_PRES_LOCK_EN
  assign presc_cmd = 1'b0;
`else
  assign presc_cmd = addr_ev & is_pres_cmd(din);
`endif

  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    div_d      = div_q;
    addr_d     = addr_q;
    dout_d     = dout_q;
    data_wr_d  = 1'b0;
    pres_upd_d = 1'b0;
    if (addr_ev) addr_d = din;
    if (data_ev) begin
      dout_d    = din;
      data_wr_d = 1'b1;
    end
    if (apply) begin
      div_d      = pend_q;
      pres_upd_d = 1'b1;
      state_d    = ST_IDLE;
    end
    // A command landing on the apply cycle overrides the return to idle.
    if (presc_cmd) begin
      pend_d  = pres_merge(pend_q, din);
      state_d = ST_PENDING;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      strb_q      <= 1'b0;
      strb_prev_q <= 1'b0;
      state_q     <= ST_IDLE;
      pend_q      <= DIV_RESET;
      div_q       <= DIV_RESET;
      addr_q      <= 8'h00;
      dout_q      <= 8'h00;
      data_wr_q   <= 1'b0;
      pres_upd_q  <= 1'b0;
    end else begin
      strb_q      <= ~cs_n & ~wr_n;
      strb_prev_q <= strb_q;
      state_q     <= state_d;
      pend_q      <= pend_d;
      div_q       <= div_d;
      addr_q      <= addr_d;
      dout_q      <= dout_d;
      data_wr_q   <= data_wr_d;
      pres_upd_q  <= pres_upd_d;
    end
  end

  jt12_busy_cnt #(
    .BUSY_CYC(BUSY_CYC)
  ) u_busy_cnt (
    .clk  (clk),
    .rst  (rst),
    .cen  (cen),
    .load (data_ev & ~rst),
    .busy (busy)
  );

  assign div_setting = div_q;
  assign addr        = addr_q;
  assign dout        = dout_q;
  assign data_wr     = data_wr_q;
  assign pres_upd    = pres_upd_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_jt12_pres_ctrl.sv
// Self-checking bench for jt12_pres_ctrl: directed scenarios plus randomized traffic vs a reference model.
module tb_jt12_pres_ctrl;
  import jt12_pres_pkg::*;

  localparam int BUSY_CYC = 4;
  localparam int W = 22;
`ifdef JT12_PRES_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, cen, clk_en_in, cs_n, wr_n, a0;
  logic [7:0]  din;
  logic [1:0]  div_setting;
  logic [7:0]  addr, dout;
  logic        data_wr, busy, pres_upd;
  pres_state_e dbg_state;

  always #5 clk = ~clk;

  jt12_pres_ctrl #(.BUSY_CYC(BUSY_CYC)) dut (
    .rst(rst), .clk(clk), .cen(cen), .clk_en_in(clk_en_in),
    .cs_n(cs_n), .wr_n(wr_n), .a0(a0), .din(din),
    .div_setting(div_setting), .addr(addr), .dout(dout),
    .data_wr(data_wr), .busy(busy), .pres_upd(pres_upd), .dbg_state(dbg_state)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];

  // Reference model state: what the outputs must be after the upcoming edge.
  bit         strobe_hist[2];
  logic [1:0] m_div, m_pend;
  logic [7:0] m_addr, m_dout;
  bit         m_data_wr, m_pres_upd, m_pending;
  int         m_busy_left;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic ref_step(input bit stb);
    bit ev;
    if (rst) begin
      m_div = 2'b10; m_pend = 2'b10; m_addr = 8'h00; m_dout = 8'h00;
      m_data_wr = 0; m_pres_upd = 0; m_pending = 0; m_busy_left = 0;
      strobe_hist[0] = 0; strobe_hist[1] = 0;
      return;
    end
    ev = strobe_hist[0] && !strobe_hist[1];
    m_data_wr  = 0;
    m_pres_upd = 0;
    if (m_pending && cen && clk_en_in) begin
      m_div = m_pend; m_pres_upd = 1; m_pending = 0;
    end
    if (ev && a0) m_busy_left = BUSY_CYC;
    else if (cen && m_busy_left > 0) m_busy_left = m_busy_left - 1;
    if (ev && !a0) begin
      m_addr = din;
      if (!LOCK && (din == 8'h2D || din == 8'h2E || din == 8'h2F)) begin
        if (din == 8'h2D) m_pend = m_pend | 2'b10;
        else if (din == 8'h2E) m_pend = m_pend | 2'b01;
        else m_pend = 2'b00;
        m_pending = 1;
      end
    end
    if (ev && a0) begin
      m_dout = din; m_data_wr = 1;
    end
    strobe_hist[1] = strobe_hist[0];
    strobe_hist[0] = stb;
  endtask

  task automatic tick(input logic r, input logic stb, input logic a, input logic [7:0] d,
                      input logic ce_m, input logic ce_f);
    logic [W-1:0] e;
    rst = r; cen = ce_m; clk_en_in = ce_f; a0 = a; din = d;
    if (stb) begin
      cs_n = 1'b0; wr_n = 1'b0;
    end else begin
      case ($urandom_range(2))
        0: begin cs_n = 1'b1; wr_n = 1'b1; end
        1: begin cs_n = 1'b0; wr_n = 1'b1; end
        default: begin cs_n = 1'b1; wr_n = 1'b0; end
      endcase
    end
    ref_step(stb);
    exp_q.push_back({m_div, m_addr, m_dout, m_data_wr, (m_busy_left != 0), m_pres_upd, m_pending});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_val("div_setting", 32'(div_setting), 32'(e[21:20]));
    check_val("addr",        32'(addr),        32'(e[19:12]));
    check_val("dout",        32'(dout),        32'(e[11:4]));
    check_val("data_wr",     32'(data_wr),     32'(e[3]));
    check_val("busy",        32'(busy),        32'(e[2]));
    check_val("pres_upd",    32'(pres_upd),    32'(e[1]));
    check_val("state",       32'(dbg_state),   32'(e[0]));
  endtask

  task automatic cpu_wr(input logic a, input logic [7:0] d);
    tick(0, 1, a, d, 0, 0);
    tick(0, 1, a, d, 0, 0);
    tick(0, 0, a, d, 0, 0);
  endtask

  initial begin
    int cnt;
    logic [7:0] rd;
    rst = 1; cen = 0; clk_en_in = 0; cs_n = 1; wr_n = 1; a0 = 0; din = 8'h00;

    // Reset values
    tick(1, 0, 0, 8'h00, 1, 1);
    tick(1, 1, 0, 8'h2F, 1, 1);
    check_val("rst_div", 32'(div_setting), 32'h2);
    check_val("rst_busy", 32'(busy), 32'h0);
    tick(0, 0, 0, 8'h00, 0, 0);

    // 0x2F then an apply cycle
    cpu_wr(0, 8'h2F);
    tick(0, 0, 0, 8'h00, 1, 1);
    check_val("c1_div", 32'(div_setting), LOCK ? 32'h2 : 32'h0);
    check_val("c1_upd", 32'(pres_upd), LOCK ? 32'h0 : 32'h1);
    tick(0, 0, 0, 8'h00, 1, 1);
    check_val("c1_upd_off", 32'(pres_upd), 32'h0);

    // 0x2D then 0x2E accumulate into one apply
    cpu_wr(0, 8'h2D);
    cpu_wr(0, 8'h2E);
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      tick(0, 0, 0, 8'h00, 1, 1);
      cnt += int'(pres_upd);
    end
    check_val("c2_div", 32'(div_setting), LOCK ? 32'h2 : 32'h3);
    check_val("c2_upd_cnt", 32'(cnt), LOCK ? 32'h0 : 32'h1);

    // 0x2F arriving on the apply cycle of a pending 2'b11
    cpu_wr(0, 8'h2D);
    tick(0, 1, 0, 8'h2F, 0, 0);
    tick(0, 1, 0, 8'h2F, 1, 1);
    check_val("c3_div", 32'(div_setting), LOCK ? 32'h2 : 32'h3);
    check_val("c3_addr", 32'(addr), 32'h2F);
    check_val("c3_state", 32'(dbg_state), LOCK ? 32'(ST_IDLE) : 32'(ST_PENDING));
    tick(0, 0, 0, 8'h00, 0, 0);
    tick(0, 0, 0, 8'h00, 1, 1);
    check_val("c3_div2", 32'(div_setting), LOCK ? 32'h2 : 32'h0);
    check_val("c3_upd2", 32'(pres_upd), LOCK ? 32'h0 : 32'h1);

    // Data write 0xA5 and busy length with cen every third clock
    tick(0, 1, 1, 8'hA5, 0, 0);
    tick(0, 1, 1, 8'hA5, 0, 0);
    check_val("c4_dout", 32'(dout), 32'hA5);
    check_val("c4_data_wr", 32'(data_wr), 32'h1);
    cnt = int'(busy);
    for (int i = 0; i < 16; i++) begin
      tick(0, 0, 1, 8'h00, (i % 3) == 2, 0);
      cnt += int'(busy);
      if (i == 0) check_val("c4_data_wr_off", 32'(data_wr), 32'h0);
    end
    check_val("c4_busy_clks", 32'(cnt), 32'd12);

    // Strobe held for 10 cycles gives exactly one data strobe
    cnt = 0;
    for (int i = 0; i < 14; i++) begin
      tick(0, i < 10, 1, 8'h3C, 0, 0);
      cnt += int'(data_wr);
    end
    check_val("c5_data_wr_cnt", 32'(cnt), 32'd1);

    // Reset while busy and pending discards both
    cpu_wr(1, 8'h55);
    cpu_wr(0, 8'h2E);
    tick(1, 0, 0, 8'h00, 1, 0);
    check_val("c6_busy", 32'(busy), 32'h0);
    check_val("c6_state", 32'(dbg_state), 32'(ST_IDLE));
    check_val("c6_div", 32'(div_setting), 32'h2);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(3))
        0: rd = 8'h2D;
        1: rd = 8'h2E;
        2: rd = 8'h2F;
        default: rd = 8'($urandom_range(255));
      endcase
      tick($urandom_range(199) == 0, $urandom_range(9) < 4, 1'($urandom_range(1)), rd,
           1'($urandom_range(1)), 1'($urandom_range(1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
